// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the SRAM arbiter: FSM state encodings, grant
// identifiers and a counter-width helper.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IF   = 2'd1,
        ST_MEM  = 2'd2
    } state_t;

    localparam logic GRANT_IF  = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_timer.sv
// Access-cycle timer: starts on start_i, stays busy for WAIT_CYCLES cycles
// and flags the final cycle with last_o.
module sram_timer
    import cpu_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic start_i,
    output logic busy_o,
    output logic last_o
);

    localparam int CNT_W = cnt_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             run;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (start_i) begin
            run <= 1'b1;
            cnt <= '0;
        end else if (run) begin
            if (cnt == CNT_LAST) begin
                run <= 1'b0;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign busy_o = run;
    assign last_o = run && (cnt == CNT_LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Single-master arbiter sharing one asynchronous SRAM between instruction fetch
// and the MEM stage. Define IFETCH_BUF_EN to add a one-entry fetch tag buffer.
module mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_done_o,
    output logic [DATA_W-1:0] instr_o,
    output logic              stall_pc_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              mem_done_o,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    input  logic [DATA_W-1:0] sram_rdata_i,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o
);

    state_t            state, next_state;
    logic              last_grant;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;
    logic              grant_if, grant_mem;
    logic              buf_hit;
    logic              acc_busy, acc_last;
    logic              if_ok, mem_ok;
    logic              if_finish, mem_finish;

    // A request seen during its own done pulse is stale: the requester has
    // not yet had a clock edge to move on to its next address.
    assign if_ok      = if_req_i & ~if_done_o;
    assign mem_ok     = mem_req_i & ~mem_done_o;
    assign if_finish  = (state == ST_IF) && acc_last;
    assign mem_finish = (state == ST_MEM) && acc_last;

`ifdef IFETCH_BUF_EN
    logic              tag_valid;
    logic [ADDR_W-1:0] tag_addr;

    assign buf_hit = (state == ST_IDLE) && if_ok && tag_valid && (tag_addr == if_addr_i);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tag_valid <= 1'b0;
            tag_addr  <= '0;
        end else if (grant_mem && mem_we_i && (mem_addr_i == tag_addr)) begin
            tag_valid <= 1'b0;
        end else if (if_finish) begin
            tag_valid <= 1'b1;
            tag_addr  <= lat_addr;
        end
    end
`else
    assign buf_hit = 1'b0;
`endif

    sram_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .CLK     (CLK),
        .RST     (RST),
        .start_i (grant_if | grant_mem),
        .busy_o  (acc_busy),
        .last_o  (acc_last)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        grant_if   = 1'b0;
        grant_mem  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!buf_hit) begin
                    if (if_ok && mem_ok) begin
                        if (last_grant == GRANT_IF) begin
                            grant_mem = 1'b1;
                        end else begin
                            grant_if = 1'b1;
                        end
                    end else if (if_ok) begin
                        grant_if = 1'b1;
                    end else if (mem_ok) begin
                        grant_mem = 1'b1;
                    end
                end
                if (grant_if) begin
                    next_state = ST_IF;
                end else if (grant_mem) begin
                    next_state = ST_MEM;
                end
            end
            ST_IF, ST_MEM: begin
                if (acc_last) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Request fields are frozen at grant so the SRAM sees stable address and
    // data for the whole access even if the requester changes its inputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            last_grant  <= GRANT_IF;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_we      <= 1'b0;
            instr_o     <= '0;
            mem_rdata_o <= '0;
            if_done_o   <= 1'b0;
            mem_done_o  <= 1'b0;
        end else begin
            if_done_o  <= if_finish | buf_hit;
            mem_done_o <= mem_finish;
            if (grant_if) begin
                last_grant <= GRANT_IF;
                lat_addr   <= if_addr_i;
                lat_we     <= 1'b0;
            end else if (grant_mem) begin
                last_grant <= GRANT_MEM;
                lat_addr   <= mem_addr_i;
                lat_wdata  <= mem_wdata_i;
                lat_we     <= mem_we_i;
            end
            if (if_finish) begin
                instr_o <= sram_rdata_i;
            end
            if (mem_finish && !lat_we) begin
                mem_rdata_o <= sram_rdata_i;
            end
        end
    end

    // Write enable is released on the final cycle so address and data are
    // still held when the SRAM latches the write on the rising we_n edge.
    assign sram_addr_o  = lat_addr;
    assign sram_wdata_o = lat_wdata;
    assign sram_ce_n_o  = ~acc_busy;
    assign sram_oe_n_o  = ~(acc_busy & ~lat_we);
    assign sram_we_n_o  = ~(acc_busy & lat_we & ~acc_last);
    assign stall_pc_o   = ~RST | (if_req_i & ~if_done_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural SRAM, scoreboard of expected
// done pulses, a vector table and hand-written multi-cycle sequences.
module tb_mem_arbiter;

    localparam int WAIT = 2;

    logic        CLK;
    logic        RST;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_done;
    logic [15:0] instr;
    logic        stall_pc;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic [15:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    int checkCount = 0;
    int passCount  = 0;

    logic [15:0] sram_mem [0:65535];
    logic [15:0] exp_if [$];
    logic [15:0] exp_mem [$];
    logic        exp_order [$];
    logic        model_last;

    typedef struct packed {
        logic        if_req;
        logic [15:0] if_addr;
        logic        mem_req;
        logic        mem_we;
        logic [15:0] mem_addr;
        logic [15:0] mem_wdata;
        logic [15:0] exp_instr;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    mem_arbiter #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .if_req_i     (if_req),
        .if_addr_i    (if_addr),
        .if_done_o    (if_done),
        .instr_o      (instr),
        .stall_pc_o   (stall_pc),
        .mem_req_i    (mem_req),
        .mem_we_i     (mem_we),
        .mem_addr_i   (mem_addr),
        .mem_wdata_i  (mem_wdata),
        .mem_done_o   (mem_done),
        .mem_rdata_o  (mem_rdata),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_rdata_i (sram_rdata),
        .sram_ce_n_o  (sram_ce_n),
        .sram_oe_n_o  (sram_oe_n),
        .sram_we_n_o  (sram_we_n)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 16'hDEAD;

    always @(posedge CLK) begin
        if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr] <= sram_wdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic reportMissing(input string name);
        checkCount++;
        $display("[TB] FAIL %s: got no done pulse expected one", name);
    endtask

    task automatic expectIf(input logic [15:0] d, input logic from_sram);
        exp_if.push_back(d);
        exp_order.push_back(1'b0);
        if (from_sram) model_last = 1'b0;
    endtask

    task automatic expectMem(input logic [15:0] d);
        exp_mem.push_back(d);
        exp_order.push_back(1'b1);
        model_last = 1'b1;
    endtask

    // Scoreboard: every done pulse must match the oldest expected transfer.
    always @(negedge CLK) begin
        logic ord;
        if (RST && (if_done || mem_done)) begin
            checkOutput("done_overlap", {31'b0, if_done & mem_done}, 32'd0);
            if (if_done) begin
                if (exp_order.size() == 0 || exp_if.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL unexpected_if_done: got pulse expected none");
                end else begin
                    ord = exp_order.pop_front();
                    checkOutput("grant_order_if", {31'b0, ord}, 32'd0);
                    checkOutput("instr_o", {16'h0, instr}, {16'h0, exp_if.pop_front()});
                end
            end
            if (mem_done) begin
                if (exp_order.size() == 0 || exp_mem.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL unexpected_mem_done: got pulse expected none");
                end else begin
                    ord = exp_order.pop_front();
                    checkOutput("grant_order_mem", {31'b0, ord}, 32'd1);
                    checkOutput("mem_rdata_o", {16'h0, mem_rdata}, {16'h0, exp_mem.pop_front()});
                end
            end
        end
    end

    task automatic waitDrop(input string name);
        for (int c = 0; c < 40 && (if_req || mem_req); c++) begin
            @(negedge CLK);
            if (if_done) if_req = 1'b0;
            if (mem_done) mem_req = 1'b0;
        end
        if (if_req || mem_req) begin
            reportMissing(name);
            if_req  = 1'b0;
            mem_req = 1'b0;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge CLK);
        #1;
        if (v.if_req && v.mem_req) begin
            if (model_last == 1'b0) begin
                expectMem(v.exp_rdata);
                expectIf(v.exp_instr, 1'b1);
            end else begin
                expectIf(v.exp_instr, 1'b1);
                expectMem(v.exp_rdata);
            end
        end else if (v.if_req) begin
            expectIf(v.exp_instr, 1'b1);
        end else begin
            expectMem(v.exp_rdata);
        end
        if_req    = v.if_req;
        if_addr   = v.if_addr;
        mem_req   = v.mem_req;
        mem_we    = v.mem_we;
        mem_addr  = v.mem_addr;
        mem_wdata = v.mem_wdata;
        waitDrop("vector_timeout");
    endtask

    initial begin
        int ce_cnt, we_cnt, done_cnt, mem_dones;

        for (int i = 0; i < 65536; i++) sram_mem[i] = 16'h0000;
        sram_mem[16'h0000] = 16'h0001;
        sram_mem[16'h0010] = 16'h1234;
        sram_mem[16'h0030] = 16'hC0DE;
        sram_mem[16'h0040] = 16'hA5A5;
        sram_mem[16'h0041] = 16'h5A5A;
        sram_mem[16'h00FF] = 16'h0BAD;
        sram_mem[16'hFFFF] = 16'h7E57;

        //           if  if_addr   mem we  mem_addr  wdata     instr     rdata
        vecs[0] = '{1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hA5A5, 16'h0000};
        vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0041, 16'h0000, 16'h0000, 16'h5A5A};
        vecs[2] = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h7E57, 16'h0000};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0001};
        vecs[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0050, 16'h3C3C, 16'h0000, 16'h0001};
        vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0050, 16'h0000, 16'h0000, 16'h3C3C};
        vecs[6] = '{1'b1, 16'h0040, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hA5A5, 16'h7E57};
        vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0000, 16'hBEEF};
        vecs[8] = '{1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0001, 16'h0000};
        vecs[9] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h0000, 16'h0BAD};

        RST = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0;
        mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; model_last = 1'b0;

        // Reset state
        repeat (2) @(negedge CLK);
        checkOutput("rst_ce_n", {31'b0, sram_ce_n}, 32'd1);
        checkOutput("rst_oe_n", {31'b0, sram_oe_n}, 32'd1);
        checkOutput("rst_we_n", {31'b0, sram_we_n}, 32'd1);
        checkOutput("rst_dones", {30'b0, if_done, mem_done}, 32'd0);
        checkOutput("rst_instr", {16'h0, instr}, 32'd0);
        checkOutput("rst_rdata", {16'h0, mem_rdata}, 32'd0);
        checkOutput("rst_addr", {16'h0, sram_addr}, 32'd0);
        checkOutput("rst_stall", {31'b0, stall_pc}, 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("idle_stall", {31'b0, stall_pc}, 32'd0);

        // Reset in the middle of a read aborts it
        @(posedge CLK); #1;
        if_req = 1'b1; if_addr = 16'h0010;
        repeat (2) @(negedge CLK);
        checkOutput("midrst_in_access", {31'b0, sram_ce_n}, 32'd0);
        RST = 1'b0;
        #1;
        checkOutput("midrst_strobes_now", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
        if_req = 1'b0;
        @(negedge CLK);
        checkOutput("midrst_strobes", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
        checkOutput("midrst_no_done", {30'b0, if_done, mem_done}, 32'd0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        checkOutput("midrst_instr", {16'h0, instr}, 32'd0);
        checkOutput("midrst_no_done2", {30'b0, if_done, mem_done}, 32'd0);
        model_last = 1'b0;

        // MEM write: we_n low for all but the last access cycle
        @(posedge CLK); #1;
        expectMem(16'h0000);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0020; mem_wdata = 16'hBEEF;
        ce_cnt = 0; we_cnt = 0;
        for (int c = 0; c < 20 && mem_req; c++) begin
            @(negedge CLK);
            if (!sram_ce_n) begin
                ce_cnt++;
                if (!sram_we_n) we_cnt++;
                checkOutput("wr_wdata", {16'h0, sram_wdata}, 32'h0000BEEF);
                checkOutput("wr_addr", {16'h0, sram_addr}, 32'h00000020);
            end
            if (mem_done) mem_req = 1'b0;
        end
        if (mem_req) begin reportMissing("wr_timeout"); mem_req = 1'b0; end
        mem_we = 1'b0;
        checkOutput("wr_ce_cycles", ce_cnt, WAIT);
        checkOutput("wr_we_cycles", we_cnt, WAIT - 1);
        checkOutput("wr_sram_content", {16'h0, sram_mem[16'h0020]}, 32'h0000BEEF);

        // IF-only fetch with stall behaviour
        @(posedge CLK); #1;
        expectIf(16'h1234, 1'b1);
        if_req = 1'b1; if_addr = 16'h0010;
        ce_cnt = 0;
        @(negedge CLK);
        checkOutput("if_stall_pending", {31'b0, stall_pc}, 32'd1);
        for (int c = 0; c < 20 && if_req; c++) begin
            if (!sram_ce_n && !sram_oe_n) ce_cnt++;
            if (if_done) begin
                checkOutput("if_stall_done", {31'b0, stall_pc}, 32'd0);
                if_req = 1'b0;
            end else begin
                @(negedge CLK);
            end
        end
        if (if_req) begin reportMissing("if_timeout"); if_req = 1'b0; end
        checkOutput("if_read_cycles", ce_cnt, WAIT);

        // Both requesting back-to-back after an IF grant: MEM, IF, MEM
        @(posedge CLK); #1;
        expectMem(16'h5A5A);
        expectIf(16'hA5A5, 1'b1);
        expectMem(16'hBEEF);
        if_req = 1'b1; if_addr = 16'h0040;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0041;
        mem_dones = 0;
        for (int c = 0; c < 60 && (if_req || mem_req); c++) begin
            @(negedge CLK);
            if (if_done) if_req = 1'b0;
            if (mem_done) begin
                mem_dones++;
                if (mem_dones == 1) mem_addr = 16'h0020;
                else mem_req = 1'b0;
            end
        end
        if (if_req || mem_req) begin reportMissing("rr_timeout"); if_req = 1'b0; mem_req = 1'b0; end

        // Request dropped after grant still completes exactly once
        @(posedge CLK); #1;
        expectMem(16'h5A5A);
        mem_req = 1'b1; mem_addr = 16'h0041;
        for (int c = 0; c < 10 && mem_req; c++) begin
            @(negedge CLK);
            if (!sram_ce_n) mem_req = 1'b0;
        end
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (mem_done) done_cnt++;
        end
        checkOutput("drop_done_count", done_cnt, 32'd1);

        for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

`ifdef IFETCH_BUF_EN
        // Repeated fetch is served from the tag buffer without an SRAM access
        applyStimulus('{1'b1, 16'h0030, 1'b0, 1'b0, 16'h0, 16'h0, 16'hC0DE, 16'h0});
        @(posedge CLK); #1;
        expectIf(16'hC0DE, 1'b0);
        if_req = 1'b1; if_addr = 16'h0030;
        ce_cnt = 0;
        for (int c = 0; c < 20 && if_req; c++) begin
            @(negedge CLK);
            if (!sram_ce_n) ce_cnt++;
            if (if_done) if_req = 1'b0;
        end
        if (if_req) begin reportMissing("buf_hit_timeout"); if_req = 1'b0; end
        checkOutput("buf_hit_no_sram", ce_cnt, 32'd0);
        applyStimulus('{1'b0, 16'h0, 1'b1, 1'b1, 16'h0030, 16'h1111, 16'h0, 16'h0BAD});
        @(posedge CLK); #1;
        expectIf(16'h1111, 1'b1);
        if_req = 1'b1; if_addr = 16'h0030;
        ce_cnt = 0;
        for (int c = 0; c < 20 && if_req; c++) begin
            @(negedge CLK);
            if (!sram_ce_n) ce_cnt++;
            if (if_done) if_req = 1'b0;
        end
        if (if_req) begin reportMissing("buf_inval_timeout"); if_req = 1'b0; end
        checkOutput("buf_inval_sram", ce_cnt, WAIT);
`endif

        repeat (3) @(negedge CLK);
        checkOutput("scoreboard_drain", exp_order.size(), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
